// File: rtl/mem_stage.sv
// Memory-access stage: waits for the data-SRAM response of loads/stores issued in
// execute, extracts load data, and drops responses orphaned by a flush.
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         es_to_ms_valid,
  input  logic [152:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [148:0] ms_to_ws_bus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  input  logic         ws_ex_forward,
  output logic         ms_ex,
  output logic [38:0]  ms_fwd_bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_e;

  localparam logic [DISCARD_W+1:0] CNT_MAX = {2'b00, {DISCARD_W{1'b1}}};

  state_e               state_q, state_d;
  logic                 ms_valid_q, ms_valid_d;
  logic [152:0]         bus_q, bus_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [DISCARD_W-1:0] discard_q, discard_d;

  logic [31:0] pc, alu_result, rt_value, badvaddr, load_src, final_result;
  logic [4:0]  dest, excode, cp0_addr;
  logic [2:0]  load_op;
  logic        gr_we, ex, mtc0_we, bd, eret, res_from_cp0;
  logic        unused_mem_req;
  logic        in_wait, resp_ok, ready_go, accept, fwd_we;

  function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd,
                                               input logic [31:0] rt,
                                               input logic [31:0] alu);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[7:0];
    case (off)
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      2'd3:    b = rd[31:24];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    r = alu;
    case (op)
      3'd1: r = {{24{b[7]}}, b};
      3'd2: r = {24'd0, b};
      3'd3: r = {{16{h[15]}}, h};
      3'd4: r = {16'd0, h};
      3'd5: r = rd;
      3'd6: begin
        case (off)
          2'd0:    r = {rd[7:0],  rt[23:0]};
          2'd1:    r = {rd[15:0], rt[15:0]};
          2'd2:    r = {rd[23:0], rt[7:0]};
          default: r = rd;
        endcase
      end
      3'd7: begin
        case (off)
          2'd0:    r = rd;
          2'd1:    r = {rt[31:24], rd[31:8]};
          2'd2:    r = {rt[31:16], rd[31:16]};
          default: r = {rt[31:8],  rd[31:24]};
        endcase
      end
      default: r = alu;
    endcase
    return r;
  endfunction

  // Increments and decrement in the same cycle net out before saturation.
  function automatic logic [DISCARD_W-1:0] cnt_update(input logic [DISCARD_W-1:0] c,
                                                      input logic inc_a,
                                                      input logic inc_b,
                                                      input logic dec);
    logic [DISCARD_W+1:0] s;
    s = {2'b00, c} + {{(DISCARD_W+1){1'b0}}, inc_a} + {{(DISCARD_W+1){1'b0}}, inc_b};
    if (dec) s = s - {{(DISCARD_W+1){1'b0}}, 1'b1};
    if (s > CNT_MAX) s = CNT_MAX;
    return s[DISCARD_W-1:0];
  endfunction

  assign pc             = bus_q[31:0];
  assign alu_result     = bus_q[63:32];
  assign dest           = bus_q[68:64];
  assign gr_we          = bus_q[69];
  assign unused_mem_req = bus_q[70];
  assign load_op        = bus_q[73:71];
  assign rt_value       = bus_q[105:74];
  assign ex             = bus_q[106];
  assign excode         = bus_q[111:107];
  assign badvaddr       = bus_q[143:112];
  assign cp0_addr       = bus_q[148:144];
  assign mtc0_we        = bus_q[149];
  assign bd             = bus_q[150];
  assign eret           = bus_q[151];
  assign res_from_cp0   = bus_q[152];

  // A response only counts as ours once every orphaned response has drained.
  assign in_wait  = (state_q == S_WAIT);
  assign resp_ok  = data_sram_data_ok && (discard_q == '0);
  assign ready_go = !in_wait || resp_ok;

  assign ms_allowin     = !ms_valid_q || (ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;

  assign load_src     = (state_q == S_HOLD) ? rdata_q : data_sram_rdata;
  assign final_result = load_extract(load_op, alu_result[1:0], load_src, rt_value, alu_result);

  assign ms_to_ws_bus = {rt_value, eret, bd, mtc0_we, cp0_addr, res_from_cp0, badvaddr,
                         ex, excode, gr_we, dest, final_result, pc};

  assign ms_ex      = ms_valid_q && (ex || eret);
  assign fwd_we     = ms_valid_q && gr_we && !ex;
  assign ms_fwd_bus = {fwd_we, fwd_we && (in_wait || res_from_cp0), dest, final_result};

  always_comb begin
    ms_valid_d = ms_valid_q;
    state_d    = state_q;
    bus_d      = bus_q;
    rdata_d    = rdata_q;
    if (ws_ex_forward) begin
      ms_valid_d = 1'b0;
      state_d    = S_IDLE;
    end else if (accept) begin
      ms_valid_d = 1'b1;
      bus_d      = es_to_ms_bus;
      state_d    = es_to_ms_bus[70] ? S_WAIT : S_IDLE;
    end else if (ms_valid_q && ready_go && ws_allowin) begin
      ms_valid_d = 1'b0;
      state_d    = S_IDLE;
    end else if (in_wait && resp_ok) begin
      state_d = S_HOLD;
      rdata_d = data_sram_rdata;
    end
    discard_d = cnt_update(discard_q,
                           ws_ex_forward && in_wait && !resp_ok,
                           ws_ex_forward && accept && es_to_ms_bus[70],
                           data_sram_data_ok && (discard_q != '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
      rdata_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      ms_valid_q <= ms_valid_d;
      bus_q      <= bus_d;
      rdata_q    <= rdata_d;
      discard_q  <= discard_d;
    end
  end

endmodule
